// File: rtl/lightbike_pkg.sv
// lightbike_pkg: grid geometry, trail-writer FSM states and grid cell codes
// shared by the light-bike game blocks.
`default_nettype none

package lightbike_pkg;

  localparam int GRID_W_DEF = 160;
  localparam int GRID_H_DEF = 120;
  localparam int ADDR_W     = 15;
  localparam int CELL_W     = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ADDR   = 3'd2,
    WAIT   = 3'd3,
    CHECK  = 3'd4,
    FINISH = 3'd5
  } state_e;

  typedef enum logic [CELL_W-1:0] {
    CELL_EMPTY = 3'd0,
    CELL_BIKE1 = 3'd1,
    CELL_BIKE2 = 3'd2,
    CELL_BIKE3 = 3'd3,
    CELL_BIKE4 = 3'd4
  } cell_e;

  // Bike index 0..3 maps onto cell codes BIKE1..BIKE4.
  function automatic logic [CELL_W-1:0] bike_code(input logic [1:0] idx);
    return CELL_BIKE1 + {1'b0, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bike_cell_addr.sv
// bike_cell_addr: maps a bike (x,y) to its linear grid cell address and
// reports whether the position lies inside the grid.
`default_nettype none

module bike_cell_addr
  import lightbike_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic [7:0]        x_i,
  input  logic [7:0]        y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_bounds_o
);

  logic [ADDR_W-1:0] x_w;
  logic [ADDR_W-1:0] y_w;

  assign x_w = {{(ADDR_W-8){1'b0}}, x_i};
  assign y_w = {{(ADDR_W-8){1'b0}}, y_i};

  // 160 = 128 + 32, so the row offset is two shifts and an add.
  generate
    if (GRID_W == 160) begin : g_shift_add
      assign addr_o = (y_w << 7) + (y_w << 5) + x_w;
    end else begin : g_mult
      assign addr_o = ADDR_W'(y_w * ADDR_W'(GRID_W)) + x_w;
    end
  endgenerate

  assign in_bounds_o = (32'(x_i) < GRID_W) && (32'(y_i) < GRID_H);

endmodule

`default_nettype wire

// File: rtl/bike_trail_writer.sv
// bike_trail_writer: per game tick, checks each live bike's cell in the grid
// RAM, crashes it on occupied/out-of-bounds cells, else stamps its trail.
`default_nettype none

module bike_trail_writer
  import lightbike_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               clear,
  input  logic [31:0]        bikeone,
  input  logic [31:0]        biketwo,
  input  logic [31:0]        bikethree,
  input  logic [31:0]        bikefour,
  output logic [ADDR_W-1:0]  grid_address,
  output logic               grid_wren,
  output logic [CELL_W-1:0]  grid_data,
  input  logic [CELL_W-1:0]  grid_q,
  output logic [3:0]         crash,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam int                CELLS     = GRID_W * GRID_H;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  state_e            state_q;
  logic [1:0]        idx_q;
  logic [15:0]       pos_q [4];
  logic [3:0]        crash_q;
  logic              overrun_q;
  logic [ADDR_W-1:0] clr_cnt_q;

  logic [ADDR_W-1:0] cell_addr_w;
  logic              in_bounds_w;
  logic              live_w;
  logic              unused_w;

  assign unused_w = ^{bikeone[31:16], biketwo[31:16], bikethree[31:16], bikefour[31:16]};

  bike_cell_addr #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_cell_addr (
    .x_i         (pos_q[idx_q][7:0]),
    .y_i         (pos_q[idx_q][15:8]),
    .addr_o      (cell_addr_w),
    .in_bounds_o (in_bounds_w)
  );

  assign live_w = !crash_q[idx_q] && in_bounds_w;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      crash_q   <= '0;
      overrun_q <= 1'b0;
      clr_cnt_q <= '0;
      for (int i = 0; i < 4; i++) pos_q[i] <= '0;
    end else begin
      if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          // Clear wins over a simultaneous tick; that tick is simply dropped.
          if (clear) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            crash_q   <= '0;
            overrun_q <= 1'b0;
          end else if (tick) begin
            pos_q[0] <= bikeone[15:0];
            pos_q[1] <= biketwo[15:0];
            pos_q[2] <= bikethree[15:0];
            pos_q[3] <= bikefour[15:0];
            idx_q    <= '0;
            state_q  <= ADDR;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == LAST_CELL) state_q <= FINISH;
          else clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
        ADDR: begin
          if (live_w) begin
            state_q <= WAIT;
          end else begin
            if (!in_bounds_w) crash_q[idx_q] <= 1'b1;
            state_q <= (idx_q == 2'd3) ? FINISH : ADDR;
            idx_q   <= idx_q + 2'd1;
          end
        end
        WAIT: state_q <= CHECK;
        CHECK: begin
          if (grid_q != CELL_EMPTY) crash_q[idx_q] <= 1'b1;
          state_q <= (idx_q == 2'd3) ? FINISH : ADDR;
          idx_q   <= idx_q + 2'd1;
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The write decision depends on this cycle's read data, so the RAM
  // controls are decoded from registered state plus grid_q.
  always_comb begin
    grid_address = '0;
    grid_wren    = 1'b0;
    grid_data    = CELL_EMPTY;
    case (state_q)
      CLEAR: begin
        grid_address = clr_cnt_q;
        grid_wren    = 1'b1;
      end
      ADDR, WAIT, CHECK: begin
        if (live_w) begin
          grid_address = cell_addr_w;
          if ((state_q == CHECK) && (grid_q == CELL_EMPTY)) begin
            grid_wren = 1'b1;
            grid_data = bike_code(idx_q);
          end
        end
      end
      default: ;
    endcase
  end

  assign crash   = crash_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FINISH);

endmodule

`default_nettype wire

// File: tb/tb_bike_trail_writer.sv
// tb_bike_trail_writer: table vectors, hand sequences and randomized steps
// for bike_trail_writer against a grid RAM and a rule-level reference model.
`default_nettype none

module tb_bike_trail_writer;

  localparam int GW    = 160;
  localparam int GH    = 120;
  localparam int CELLS = GW * GH;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick  = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] bikeone = '0, biketwo = '0, bikethree = '0, bikefour = '0;
  logic [14:0] grid_address;
  logic        grid_wren;
  logic [2:0]  grid_data;
  logic [2:0]  grid_q;
  logic [3:0]  crash;
  logic        busy, done, overrun;

  bike_trail_writer #(.GRID_W(GW), .GRID_H(GH)) dut (
    .clock(clock), .reset(reset), .tick(tick), .clear(clear),
    .bikeone(bikeone), .biketwo(biketwo), .bikethree(bikethree), .bikefour(bikefour),
    .grid_address(grid_address), .grid_wren(grid_wren), .grid_data(grid_data),
    .grid_q(grid_q), .crash(crash), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Grid RAM: one-cycle registered read; bench-side zero/preload ports.
  logic [2:0]  ram [0:32767];
  logic [2:0]  q_r = 3'd0;
  logic        ram_zero = 1'b0, pre_en = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [2:0]  pre_data = '0;

  always @(posedge clock) begin
    if (ram_zero) for (int i = 0; i < 32768; i++) ram[i] <= 3'd0;
    else if (pre_en) ram[pre_addr] <= pre_data;
    else if (grid_wren) ram[grid_address] <= grid_data;
    q_r <= ram[grid_address];
  end
  assign grid_q = q_r;

  typedef struct packed { logic [14:0] a; logic [2:0] d; } wr_t;
  wr_t wr_q[$];
  wr_t exp_wr[$];

  always @(negedge clock) if (grid_wren) wr_q.push_back({grid_address, grid_data});

  // Reference model state.
  logic [2:0] ref_mem [0:CELLS-1];
  logic [3:0] ref_crash = '0;
  logic       ref_ovr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0][15:0] pos;
    logic [3:0]       crash;
    int               lat;
    int               nwr;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] xy(input int x, input int y);
    return {y[7:0], x[7:0]};
  endfunction

  task automatic fresh();
    @(negedge clock); reset = 1'b1; ram_zero = 1'b1;
    @(negedge clock); ram_zero = 1'b0; reset = 1'b0;
    for (int i = 0; i < CELLS; i++) ref_mem[i] = 3'd0;
    ref_crash = '0; ref_ovr = 1'b0;
    wr_q.delete();
  endtask

  // One step by the game rules: lower index first, each bike crashes on
  // leaving the grid or landing on any non-empty cell.
  task automatic model_step(input logic [3:0][15:0] p, output int lat);
    int x, y, a;
    lat = 1;
    exp_wr.delete();
    for (int i = 0; i < 4; i++) begin
      x = int'(p[i][7:0]);
      y = int'(p[i][15:8]);
      if (ref_crash[i]) lat += 1;
      else if (x >= GW || y >= GH) begin ref_crash[i] = 1'b1; lat += 1; end
      else begin
        a = y * GW + x;
        lat += 3;
        if (ref_mem[a] != 3'd0) ref_crash[i] = 1'b1;
        else begin
          ref_mem[a] = 3'(i + 1);
          exp_wr.push_back({15'(a), 3'(i + 1)});
        end
      end
    end
  endtask

  task automatic do_step(input logic [3:0][15:0] p, input int extra, output int lat);
    bikeone = {16'hDEAD, p[0]}; biketwo = {16'hBEEF, p[1]};
    bikethree = {16'h1234, p[2]}; bikefour = {16'hFFFF, p[3]};
    wr_q.delete();
    @(negedge clock); tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin lat = c; break; end
      if (c == 1) begin
        check("busy_in_step", busy, 1'b1);
        bikeone = $urandom; biketwo = $urandom; bikethree = $urandom; bikefour = $urandom;
      end
      tick = (c == extra);
      @(negedge clock);
    end
    tick = 1'b0;
    @(negedge clock);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic cmp_writes(input string nm);
    check({nm, "_nwr"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      check({nm, "_wr"}, 32'(wr_q[i]), 32'(exp_wr[i]));
  endtask

  task automatic step_and_check(input string nm, input logic [3:0][15:0] p, input int extra,
                                output int lat);
    int mlat;
    model_step(p, mlat);
    if (extra > 0) ref_ovr = 1'b1;
    do_step(p, extra, lat);
    check({nm, "_latency"}, lat, mlat);
    check({nm, "_crash"}, crash, ref_crash);
    check({nm, "_overrun"}, overrun, ref_ovr);
    cmp_writes(nm);
  endtask

  function automatic logic [15:0] rand_pos();
    int x, y;
    x = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 200) : $urandom_range(0, 5);
    y = ($urandom_range(0, 3) == 0) ? $urandom_range(115, 140) : $urandom_range(0, 3);
    return xy(x, y);
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bad;
    logic [3:0][15:0] p;
    int exp_a [4];
    exp_a = '{0, 19199, 810, 9680};

    vt[0].pos = {xy(80, 60), xy(10, 5), xy(159, 119), xy(0, 0)};
    vt[0].crash = 4'b0000; vt[0].lat = 13; vt[0].nwr = 4;
    vt[1].pos = {xy(3, 3), xy(2, 2), xy(1, 1), xy(200, 3)};
    vt[1].crash = 4'b0001; vt[1].lat = 11; vt[1].nwr = 3;
    vt[2].pos = {xy(30, 30), xy(7, 7), xy(7, 7), xy(0, 0)};
    vt[2].crash = 4'b0100; vt[2].lat = 13; vt[2].nwr = 3;
    vt[3].pos = {xy(159, 120), xy(255, 255), xy(0, 120), xy(160, 0)};
    vt[3].crash = 4'b1111; vt[3].lat = 5;  vt[3].nwr = 0;
    vt[4].pos = {xy(0, 200), xy(5, 5), xy(5, 5), xy(5, 5)};
    vt[4].crash = 4'b1110; vt[4].lat = 11; vt[4].nwr = 1;

    // Reset state
    fresh();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wren", grid_wren, 1'b0);
    check("rst_addr", grid_address, 15'd0);
    check("rst_data", grid_data, 3'd0);
    check("rst_crash", crash, 4'd0);
    check("rst_overrun", overrun, 1'b0);

    for (int i = 0; i < 5; i++) begin
      fresh();
      step_and_check("vec", vt[i].pos, 0, lat);
      check("vec_tab_latency", lat, vt[i].lat);
      check("vec_tab_crash", crash, vt[i].crash);
      check("vec_tab_nwr", wr_q.size(), vt[i].nwr);
      if (i == 0 && wr_q.size() == 4)
        for (int k = 0; k < 4; k++) begin
          check("vec0_addr", wr_q[k].a, exp_a[k]);
          check("vec0_data", wr_q[k].d, k + 1);
        end
      if (i == 2 && wr_q.size() >= 2) begin
        check("same_cell_addr", wr_q[1].a, 15'd1127);
        check("same_cell_data", wr_q[1].d, 3'd2);
      end
    end

    // Preloaded cell: bike 0 crashes without writing, then is skipped.
    fresh();
    @(negedge clock); pre_addr = 15'd810; pre_data = 3'd4; pre_en = 1'b1;
    @(negedge clock); pre_en = 1'b0;
    ref_mem[810] = 3'd4;
    p = {xy(3, 0), xy(2, 0), xy(1, 0), xy(10, 5)};
    step_and_check("preload", p, 0, lat);
    check("preload_latency", lat, 13);
    check("preload_crash", crash, 4'b0001);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i].a == 15'd810) bad++;
    check("preload_no_write_810", bad, 0);
    p = {xy(3, 1), xy(2, 1), xy(1, 1), xy(10, 5)};
    step_and_check("skip", p, 0, lat);
    check("skip_latency", lat, 11);
    check("skip_crash", crash, 4'b0001);

    // Tick while busy
    p = {xy(23, 30), xy(22, 30), xy(21, 30), xy(20, 30)};
    step_and_check("overrun", p, 4, lat);
    check("overrun_set", overrun, 1'b1);

    // Clear with simultaneous tick
    wr_q.delete();
    @(negedge clock); clear = 1'b1; tick = 1'b1;
    @(negedge clock); clear = 1'b0; tick = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20000; c++) begin
      if (done) begin lat = c; break; end
      @(negedge clock);
    end
    check("clear_latency", lat, CELLS + 1);
    check("clear_nwr", wr_q.size(), CELLS);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i].a != 15'(i) || wr_q[i].d != 3'd0) bad++;
    check("clear_sequence", bad, 0);
    check("clear_crash", crash, 4'd0);
    check("clear_overrun", overrun, 1'b0);
    repeat (3) @(negedge clock);
    check("clear_tick_dropped_busy", busy, 1'b0);
    check("clear_tick_dropped_nwr", wr_q.size(), CELLS);
    for (int i = 0; i < CELLS; i++) ref_mem[i] = 3'd0;
    ref_crash = '0; ref_ovr = 1'b0;

    // Reset mid-step
    p = {xy(43, 9), xy(42, 9), xy(41, 9), xy(40, 9)};
    bikeone = {16'd0, p[0]}; biketwo = {16'd0, p[1]};
    bikethree = {16'd0, p[2]}; bikefour = {16'd0, p[3]};
    @(negedge clock); tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    repeat (4) @(negedge clock);
    check("midstep_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_wren", grid_wren, 1'b0);
    check("midrst_addr", grid_address, 15'd0);
    check("midrst_data", grid_data, 3'd0);
    check("midrst_crash", crash, 4'd0);
    check("midrst_overrun", overrun, 1'b0);
    @(negedge clock); ram_zero = 1'b1;
    @(negedge clock); ram_zero = 1'b0; reset = 1'b0;
    for (int i = 0; i < CELLS; i++) ref_mem[i] = 3'd0;
    ref_crash = '0; ref_ovr = 1'b0;
    p = {xy(15, 12), xy(14, 12), xy(13, 12), xy(12, 12)};
    step_and_check("after_rst", p, 0, lat);
    check("after_rst_latency", lat, 13);

    // Randomized steps against the model
    for (int r = 0; r < 24; r++) begin
      if (r % 6 == 0) fresh();
      for (int i = 0; i < 4; i++) p[i] = rand_pos();
      step_and_check("rand", p, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
